// File: rtl/char_serializer_if.sv
// Load port and character stream of char_serializer.
// The producer drives the load handshake through the master modport.
// The serializer uses the slave modport.
// out / out_valid feed the downstream BlockChecker.
interface char_serializer_if #(
    parameter int CHARS = 8,
    parameter int LW    = $clog2(CHARS + 1)
);
    logic                 ld_valid;
    logic                 ld_ready;
    logic [8*CHARS-1:0]   ld_data;
    logic [LW-1:0]        ld_len;
    logic [7:0]           out;
    logic                 out_valid;
    logic                 busy;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_len,
        input  ld_ready,
        input  out,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_len,
        output ld_ready,
        output out,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/char_serializer.sv
// char_serializer: accepts strings of up to CHARS bytes and emits them one
// byte per clock. A one-entry pending buffer sits in front of the active
// shifter, so back-to-back strings stream with no gap. When nothing is
// loaded the output carries FILL with out_valid low.
module char_serializer #(
    parameter int          CHARS = 8,
    parameter logic [7:0]  FILL  = 8'h20,
    parameter int          LW    = $clog2(CHARS + 1)
) (
    input  logic               clk,
    input  logic               reset,   // asynchronous, active low
    char_serializer_if.slave   bus
);

    localparam int            DW      = 8 * CHARS;
    localparam logic [LW-1:0] MAX_LEN = LW'(CHARS);
    localparam logic [LW-1:0] ONE     = LW'(1);

    // Active shifter: the string currently being emitted, next byte on top.
    logic [DW-1:0] act_q,  act_d;
    logic [LW-1:0] rem_q,  rem_d;

    // Pending buffer: the string that follows the active one.
    logic [DW-1:0] pend_q, pend_d;
    logic [LW-1:0] plen_q, plen_d;
    logic          pfull_q, pfull_d;

    // Registered output stream.
    logic [7:0]    out_q, out_d;
    logic          out_valid_q, out_valid_d;

    logic [LW-1:0] len_clamped;
    logic          ld_ready;
    logic          xfer;

    // Clamp over-long lengths to the shifter capacity.
    always_comb begin
        len_clamped = bus.ld_len;
        if (bus.ld_len > MAX_LEN) begin
            len_clamped = MAX_LEN;
        end
    end

    // The pending slot is free, or it will drain into the shifter at this edge.
    assign ld_ready = !pfull_q || (rem_q == '0);
    assign xfer     = bus.ld_valid && ld_ready;

    assign bus.ld_ready  = ld_ready;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (rem_q != '0) || pfull_q;

    // Next state: emit from the shifter, else promote the pending string, else emit fill.
    // Then capture an accepted non-empty load into the pending slot.
    always_comb begin
        act_d       = act_q;
        rem_d       = rem_q;
        pend_d      = pend_q;
        plen_d      = plen_q;
        pfull_d     = pfull_q;
        out_d       = FILL;
        out_valid_d = 1'b0;

        if (rem_q != '0) begin
            out_d       = act_q[DW-1 -: 8];
            act_d       = act_q << 8;
            rem_d       = rem_q - ONE;
            out_valid_d = 1'b1;
        end else if (pfull_q) begin
            // The first pending byte goes straight out, and the rest moves into the shifter.
            out_d       = pend_q[DW-1 -: 8];
            act_d       = pend_q << 8;
            rem_d       = plen_q - ONE;
            pfull_d     = 1'b0;
            out_valid_d = 1'b1;
        end

        // A refill in the same cycle as the promotion keeps the slot full.
        // Empty loads are consumed and dropped.
        if (xfer && (len_clamped != '0)) begin
            pend_d  = bus.ld_data;
            plen_d  = len_clamped;
            pfull_d = 1'b1;
        end
    end

    // State registers. Reset discards any held characters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_q       <= '0;
            rem_q       <= '0;
            pend_q      <= '0;
            plen_q      <= '0;
            pfull_q     <= 1'b0;
            out_q       <= FILL;
            out_valid_q <= 1'b0;
        end else begin
            act_q       <= act_d;
            rem_q       <= rem_d;
            pend_q      <= pend_d;
            plen_q      <= plen_d;
            pfull_q     <= pfull_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_char_serializer.sv
// Directed testbench for char_serializer. Expected values are hand-derived
// from the load/emit timing. Every comparison goes through check().
module tb_char_serializer;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    char_serializer_if #(.CHARS(8)) bus ();

    char_serializer #(.CHARS(8), .FILL(8'h20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Left-align a string: s[0] lands in bits [63:56].
    function automatic logic [63:0] pack(input string s);
        logic [63:0] d;
        d = '0;
        for (int i = 0; i < s.len() && i < 8; i++) begin
            d[63 - 8*i -: 8] = s[i];
        end
        return d;
    endfunction

    task automatic drive(input string s, input logic [3:0] len);
        bus.ld_valid = 1'b1;
        bus.ld_data  = pack(s);
        bus.ld_len   = len;
        $display("load \"%s\" len=%0d", s, len);
    endtask

    task automatic expect_str(input string tag, input string s);
        for (int i = 0; i < s.len(); i++) begin
            tick();
            check($sformatf("%s_char%0d", tag, i), bus.out, s[i]);
            check($sformatf("%s_valid%0d", tag, i), bus.out_valid, 1'b1);
        end
    endtask

    task automatic expect_fill(input string tag);
        tick();
        check({tag, "_fill"}, bus.out, 8'h20);
        check({tag, "_fillv"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        string s4;
        vectors     = 0;
        miscompares = 0;

        // Reset with a load offered. It must not be accepted.
        reset = 1'b1;
        drive("begin", 4'd5);
        #2 reset = 1'b0;
        repeat (3) tick();
        check("rst_out", bus.out, 8'h20);
        check("rst_outv", bus.out_valid, 1'b0);
        check("rst_ready", bus.ld_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        bus.ld_valid = 1'b0;
        reset = 1'b1;
        expect_fill("post_rst0");
        check("post_rst_busy", bus.busy, 1'b0);
        expect_fill("post_rst1");

        // Single string.
        drive("begin", 4'd5);
        tick();
        bus.ld_valid = 1'b0;
        check("single_busy_acc", bus.busy, 1'b1);
        expect_str("single", "begin");
        check("single_busy_end", bus.busy, 1'b0);
        expect_fill("single");

        // Back-to-back strings: the second is accepted while the first starts.
        drive("begin ", 4'd6);
        tick();
        check("b2b_ready_idle", bus.ld_ready, 1'b1);
        drive("end ", 4'd4);
        tick();
        bus.ld_valid = 1'b0;
        check("b2b_c0", bus.out, "b");
        check("b2b_v0", bus.out_valid, 1'b1);
        check("b2b_ready_wait", bus.ld_ready, 1'b0);
        expect_str("b2b_a", "egin");
        check("b2b_ready_last", bus.ld_ready, 1'b0);
        expect_str("b2b_b", " ");
        check("b2b_ready_rise", bus.ld_ready, 1'b1);
        expect_str("b2b_c", "end ");
        check("b2b_busy_end", bus.busy, 1'b0);
        expect_fill("b2b");

        // Length-1 strings, one per cycle.
        s4 = "end ";
        for (int i = 0; i < 4; i++) begin
            drive(s4.substr(i, i), 4'd1);
            tick();
            check($sformatf("len1_ready%0d", i), bus.ld_ready, 1'b1);
            if (i > 0) begin
                check($sformatf("len1_char%0d", i - 1), bus.out, s4[i-1]);
                check($sformatf("len1_valid%0d", i - 1), bus.out_valid, 1'b1);
            end
        end
        bus.ld_valid = 1'b0;
        expect_str("len1_last", " ");
        expect_fill("len1");

        // Empty load is consumed and dropped.
        drive("xxxxxxxx", 4'd0);
        tick();
        bus.ld_valid = 1'b0;
        check("len0_busy", bus.busy, 1'b0);
        check("len0_ready", bus.ld_ready, 1'b1);
        expect_fill("len0");

        // Over-long length clamps to 8.
        drive("ABCDEFGH", 4'd15);
        tick();
        bus.ld_valid = 1'b0;
        expect_str("len15", "ABCDEFGH");
        check("len15_busy", bus.busy, 1'b0);
        expect_fill("len15");

        // Reset mid-string clears the output without a clock edge.
        drive("begin", 4'd5);
        tick();
        bus.ld_valid = 1'b0;
        expect_str("mid", "be");
        reset = 1'b0;
        #1;
        check("mid_rst_out", bus.out, 8'h20);
        check("mid_rst_outv", bus.out_valid, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_ready", bus.ld_ready, 1'b1);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_fill($sformatf("mid_after%0d", i));
        end
        check("mid_busy_after", bus.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
